fx2_stream_writer: RTL and testbench

Buffers 32-bit {Q,I} sample words from the decimating FIR output and writes them, one byte per clock, into the FX2LP slave FIFO. It replaces the inline byte serializer in the SDR top level. It adds the following:
- a word FIFO that absorbs FIR bursts;
- full-flag flow control;
- overflow accounting;
- optional short-packet commit via PKTEND.

---
 rtl/fx2_stream_writer_if.sv | 23 ++
 rtl/fx2_stream_writer.sv | 149 ++++++++++++++
 tb/tb_fx2_stream_writer.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fx2_stream_writer_if.sv
// Sample-stream and FX2LP slave-FIFO signals of fx2_stream_writer.
// The writer block takes the slave modport; the FIR side and FX2 pins drive the master modport.
interface fx2_stream_writer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        iq_swap;
  logic        full_n;
  logic [7:0]  fd;
  logic        slwr_n;
  logic        pktend_n;
  logic [15:0] ovf_count;

  modport master (
    output in_data, in_valid, iq_swap, full_n,
    input  in_ready, fd, slwr_n, pktend_n, ovf_count
  );

  modport slave (
    input  in_data, in_valid, iq_swap, full_n,
    output in_ready, fd, slwr_n, pktend_n, ovf_count
  );
endinterface

// File: rtl/fx2_stream_writer.sv
// Word FIFO plus little-endian byte serializer feeding the FX2LP slave FIFO (one byte per IFCLK).
// Optional macro FX2_FLUSH_EN: commit a partial packet with PKTEND after FLUSH_TIMEOUT idle clocks.
module fx2_stream_writer #(
  parameter int DEPTH_LOG2    = 4,
  parameter int PKT_BYTES     = 512,
  parameter int FLUSH_TIMEOUT = 4800
) (
  input logic                clk,
  input logic                reset,
  fx2_stream_writer_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BCW   = $clog2(PKT_BYTES);
  localparam logic [BCW-1:0] BC_LAST = BCW'(PKT_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, B0, B1, B2, B3
`ifdef FX2_FLUSH_EN
    , PEND
`endif
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] swap_halves(input logic [31:0] w, input logic sw);
    return sw ? {w[15:0], w[31:16]} : w;
  endfunction

  state_e              state_q;
  logic [31:0]         mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]         shreg_q;
  logic [7:0]          fd_q;
  logic                slwr_n_q;
  logic [15:0]         ovf_q;
  logic [BCW-1:0]      byte_cnt_q;

  logic                  fifo_empty, fifo_full;
  logic                  push, drop, pop;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic [31:0]           pop_word;

  // The extra pointer MSB distinguishes full from empty when the indices wrap onto each other.
  assign wr_idx     = wr_ptr_q[DEPTH_LOG2-1:0];
  assign rd_idx     = rd_ptr_q[DEPTH_LOG2-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) && (wr_idx == rd_idx);

  assign bus.in_ready = !fifo_full && !reset;
  assign push         = bus.in_valid && bus.in_ready;
  assign drop         = bus.in_valid && !bus.in_ready;
  assign pop          = ((state_q == IDLE) || (state_q == B3)) && !fifo_empty && bus.full_n;
  assign pop_word     = swap_halves(mem_q[rd_idx], bus.iq_swap);

  assign bus.fd        = fd_q;
  assign bus.slwr_n    = slwr_n_q;
  assign bus.ovf_count = ovf_q;

`ifdef FX2_FLUSH_EN
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(FLUSH_TIMEOUT - 1);

  logic [TW-1:0] timer_q;
  logic          pktend_n_q;
  logic          flush_cond;

  assign flush_cond   = (state_q == IDLE) && fifo_empty && (byte_cnt_q != '0) && !push;
  assign bus.pktend_n = pktend_n_q;
`else
  logic unused_flush;

  // Without the flush feature the byte count and timeout have no consumer.
  assign unused_flush = ^{byte_cnt_q, 32'(FLUSH_TIMEOUT)};
  assign bus.pktend_n = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fd_q       <= 8'h00;
      slwr_n_q   <= 1'b1;
      ovf_q      <= '0;
      byte_cnt_q <= '0;
`ifdef FX2_FLUSH_EN
      timer_q    <= '0;
      pktend_n_q <= 1'b1;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) ovf_q    <= sat_inc16(ovf_q);
      if (!slwr_n_q) byte_cnt_q <= (byte_cnt_q == BC_LAST) ? '0 : byte_cnt_q + 1'b1;
`ifdef FX2_FLUSH_EN
      if (!flush_cond)            timer_q <= '0;
      else if (timer_q != TO_LAST) timer_q <= timer_q + 1'b1;
`endif
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q  <= B0;
            shreg_q  <= pop_word >> 8;
            fd_q     <= pop_word[7:0];
            slwr_n_q <= 1'b0;
          end
`ifdef FX2_FLUSH_EN
          else if (flush_cond && (timer_q == TO_LAST) && bus.full_n) begin
            state_q    <= PEND;
            pktend_n_q <= 1'b0;
          end
`endif
        end
        B0, B1, B2: begin
          state_q <= (state_q == B0) ? B1 : (state_q == B1) ? B2 : B3;
          fd_q    <= shreg_q[7:0];
          shreg_q <= shreg_q >> 8;
        end
        B3: begin
          if (pop) begin
            state_q <= B0;
            shreg_q <= pop_word >> 8;
            fd_q    <= pop_word[7:0];
          end else begin
            state_q  <= IDLE;
            slwr_n_q <= 1'b1;
          end
        end
`ifdef FX2_FLUSH_EN
        PEND: begin
          state_q    <= IDLE;
          pktend_n_q <= 1'b1;
          byte_cnt_q <= '0;
        end
`endif
        default: begin
          state_q  <= IDLE;
          slwr_n_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fx2_stream_writer.sv
// Self-checking bench for fx2_stream_writer: directed scenarios plus a randomized stream
// compared against a byte-queue reference model.
module tb_fx2_stream_writer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fx2_stream_writer_if bus_if();

  fx2_stream_writer #(
    .DEPTH_LOG2   (4),
    .PKT_BYTES    (512),
    .FLUSH_TIMEOUT(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] got[$];
  int   byte_idx = 0, viol = 0, cyc = 0, last_byte_cyc = 0, pk_cnt = 0, pk_cyc = 0;
  logic fn_edge;

  always @(posedge clk) fn_edge <= bus_if.full_n;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      byte_idx <= 0;
    end else begin
      if (bus_if.slwr_n === 1'b0) begin
        got.push_back(bus_if.fd);
        if ((byte_idx % 4 == 0) && (fn_edge !== 1'b1)) viol <= viol + 1;
        byte_idx      <= byte_idx + 1;
        last_byte_cyc <= cyc;
      end
      if (bus_if.pktend_n === 1'b0) begin
        pk_cnt <= pk_cnt + 1;
        pk_cyc <= cyc;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input logic sw, input int k);
    logic [31:0] x;
    x = sw ? {w[15:0], w[31:16]} : w;
    return x[8*k +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    bus_if.iq_swap  = 1'b0;
    bus_if.full_n   = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    bus_if.iq_swap  = 1'b0;
    bus_if.full_n   = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    n_checks++;
    if (bus_if.in_ready !== 1'b0) $display("FAIL reset_in_ready_held: got %b want 0", bus_if.in_ready); else n_pass++;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_if.fd !== 8'h00) $display("FAIL reset_fd: got %h want 00", bus_if.fd); else n_pass++;
    n_checks++;
    if (bus_if.slwr_n !== 1'b1) $display("FAIL reset_slwr_n: got %b want 1", bus_if.slwr_n); else n_pass++;
    n_checks++;
    if (bus_if.pktend_n !== 1'b1) $display("FAIL reset_pktend_n: got %b want 1", bus_if.pktend_n); else n_pass++;
    n_checks++;
    if (bus_if.ovf_count !== 16'd0) $display("FAIL reset_ovf: got %0d want 0", bus_if.ovf_count); else n_pass++;
    n_checks++;
    if (bus_if.in_ready !== 1'b1) $display("FAIL reset_in_ready_after: got %b want 1", bus_if.in_ready); else n_pass++;
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    do_reset();
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 32'hA1B2C3D4;
    tick();
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_if.slwr_n !== 1'b1) $display("FAIL single_idle_at_push: slwr_n got %b want 1", bus_if.slwr_n); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus_if.slwr_n !== 1'b0) $display("FAIL single_strobe%0d: slwr_n got %b want 0", k, bus_if.slwr_n); else n_pass++;
      n_checks++;
      if (bus_if.fd !== exp_b[k]) $display("FAIL single_byte%0d: fd got %h want %h", k, bus_if.fd, exp_b[k]); else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.slwr_n !== 1'b1) $display("FAIL single_end: slwr_n got %b want 1", bus_if.slwr_n); else n_pass++;
    tick();
  endtask

  task automatic test_swap();
    logic [7:0] exp_b [4];
    exp_b = '{8'h22, 8'h11, 8'h44, 8'h33};
    do_reset();
    bus_if.iq_swap  = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 32'h11223344;
    tick();
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_if.slwr_n !== 1'b1) $display("FAIL swap_idle_at_push: slwr_n got %b want 1", bus_if.slwr_n); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus_if.slwr_n !== 1'b0) $display("FAIL swap_strobe%0d: slwr_n got %b want 0", k, bus_if.slwr_n); else n_pass++;
      n_checks++;
      if (bus_if.fd !== exp_b[k]) $display("FAIL swap_byte%0d: fd got %h want %h", k, bus_if.fd, exp_b[k]); else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.slwr_n !== 1'b1) $display("FAIL swap_end: slwr_n got %b want 1", bus_if.slwr_n); else n_pass++;
    tick();
    bus_if.iq_swap = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] w [8];
    int base, run, best, lows;
    do_reset();
    for (int i = 0; i < 8; i++) w[i] = $urandom();
    base = got.size();
    run = 0; best = 0; lows = 0;
    for (int c = 0; c < 46; c++) begin
      bus_if.in_valid = (c % 4 == 0) && (c < 32);
      bus_if.in_data  = w[(c / 4) % 8];
      @(negedge clk);
      if (bus_if.slwr_n === 1'b0) begin
        run++; lows++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      tick();
    end
    bus_if.in_valid = 1'b0;
    n_checks++;
    if (best != 32) $display("FAIL stream_contiguous: longest run got %0d want 32", best); else n_pass++;
    n_checks++;
    if (lows != 32) $display("FAIL stream_total: strobes got %0d want 32", lows); else n_pass++;
    n_checks++;
    if (bus_if.ovf_count !== 16'd0) $display("FAIL stream_ovf: got %0d want 0", bus_if.ovf_count); else n_pass++;
    if (got.size() >= base + 32) begin
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if (got[base+i] !== exp_byte(w[i/4], 1'b0, i % 4))
          $display("FAIL stream_byte%0d: got %h want %h", i, got[base+i], exp_byte(w[i/4], 1'b0, i % 4));
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [20];
    logic er;
    int base;
    do_reset();
    bus_if.full_n = 1'b0;
    base = got.size();
    for (int k = 0; k < 20; k++) begin
      w[k] = $urandom();
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = w[k];
      er = (k < 16);
      @(negedge clk);
      n_checks++;
      if (bus_if.in_ready !== er) $display("FAIL bp_in_ready_word%0d: got %b want %b", k, bus_if.in_ready, er); else n_pass++;
      tick();
    end
    bus_if.in_valid = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (got.size() != base) $display("FAIL bp_no_writes: bytes got %0d want 0", got.size() - base); else n_pass++;
    n_checks++;
    if (bus_if.ovf_count !== 16'd4) $display("FAIL bp_ovf: got %0d want 4", bus_if.ovf_count); else n_pass++;
    bus_if.full_n = 1'b1;
    repeat (80) tick();
    n_checks++;
    if (got.size() != base + 64) $display("FAIL bp_drain_count: bytes got %0d want 64", got.size() - base); else n_pass++;
    if (got.size() >= base + 64) begin
      for (int i = 0; i < 64; i++) begin
        n_checks++;
        if (got[base+i] !== exp_byte(w[i/4], 1'b0, i % 4))
          $display("FAIL bp_byte%0d: got %h want %h", i, got[base+i], exp_byte(w[i/4], 1'b0, i % 4));
        else n_pass++;
      end
    end
  endtask

  task automatic test_midword_stall();
    logic [31:0] w0, w1;
    int base, v0;
    do_reset();
    w0 = $urandom(); w1 = $urandom();
    base = got.size();
    v0 = viol;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = w0;
    tick();
    bus_if.in_data  = w1;
    tick();
    bus_if.in_valid = 1'b0;
    tick();
    bus_if.full_n = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (got.size() != base + 4) $display("FAIL stall_first_word: bytes got %0d want 4", got.size() - base); else n_pass++;
    bus_if.full_n = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (got.size() != base + 8) $display("FAIL stall_resume: bytes got %0d want 8", got.size() - base); else n_pass++;
    if (got.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (got[base+i] !== exp_byte((i < 4) ? w0 : w1, 1'b0, i % 4))
          $display("FAIL stall_byte%0d: got %h want %h", i, got[base+i], exp_byte((i < 4) ? w0 : w1, 1'b0, i % 4));
        else n_pass++;
      end
    end
    n_checks++;
    if (viol != v0) $display("FAIL stall_fulln_rule: word starts with full_n=0 got %0d want 0", viol - v0); else n_pass++;
  endtask

  task automatic test_reset_midword();
    int base;
    do_reset();
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = $urandom();
    tick();
    bus_if.in_data  = $urandom();
    tick();
    bus_if.in_data  = $urandom();
    tick();
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_if.slwr_n !== 1'b0) $display("FAIL rstmid_active: slwr_n got %b want 0", bus_if.slwr_n); else n_pass++;
    reset = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (bus_if.slwr_n !== 1'b1) $display("FAIL rstmid_abandon: slwr_n got %b want 1", bus_if.slwr_n); else n_pass++;
    n_checks++;
    if (bus_if.in_ready !== 1'b0) $display("FAIL rstmid_in_ready: got %b want 0", bus_if.in_ready); else n_pass++;
    tick();
    reset = 1'b0;
    base = got.size();
    repeat (20) tick();
    n_checks++;
    if (got.size() != base) $display("FAIL rstmid_discard: bytes got %0d want 0", got.size() - base); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus_if.in_ready !== 1'b1) $display("FAIL rstmid_ready_after: got %b want 1", bus_if.in_ready); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [31:0] w;
    logic sw;
    int base, v0, pushed, gap;
    do_reset();
    sw = 1'($urandom_range(0, 1));
    bus_if.iq_swap = sw;
    base = got.size();
    v0 = viol;
    pushed = 0;
    gap = 0;
    while (pushed < 12) begin
      bus_if.full_n = ($urandom_range(0, 3) != 0);
      if (gap == 0) begin
        w = $urandom();
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = w;
        for (int k = 0; k < 4; k++) exp_q.push_back(exp_byte(w, sw, k));
        pushed++;
        gap = $urandom_range(0, 5);
      end else begin
        bus_if.in_valid = 1'b0;
        gap--;
      end
      @(negedge clk);
      n_checks++;
      if (bus_if.in_ready !== 1'b1) $display("FAIL rand_in_ready: got %b want 1", bus_if.in_ready); else n_pass++;
      tick();
    end
    bus_if.in_valid = 1'b0;
    bus_if.full_n = 1'b1;
    repeat (70) tick();
    n_checks++;
    if (got.size() != base + exp_q.size()) $display("FAIL rand_count: bytes got %0d want %0d", got.size() - base, exp_q.size()); else n_pass++;
    if (got.size() >= base + exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got[base+i] !== exp_q[i]) $display("FAIL rand_byte%0d: got %h want %h", i, got[base+i], exp_q[i]); else n_pass++;
      end
    end
    n_checks++;
    if (bus_if.ovf_count !== 16'd0) $display("FAIL rand_ovf: got %0d want 0", bus_if.ovf_count); else n_pass++;
    n_checks++;
    if (viol != v0) $display("FAIL rand_fulln_rule: word starts with full_n=0 got %0d want 0", viol - v0); else n_pass++;
    bus_if.iq_swap = 1'b0;
  endtask

`ifdef FX2_FLUSH_EN
  task automatic test_flush();
    int pk0;
    do_reset();
    pk0 = pk_cnt;
    for (int i = 0; i < 3; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = $urandom();
      tick();
      bus_if.in_valid = 1'b0;
      repeat (3) tick();
    end
    repeat (40) tick();
    n_checks++;
    if (pk_cnt - pk0 != 1) $display("FAIL flush_pulse_count: got %0d want 1", pk_cnt - pk0); else n_pass++;
    n_checks++;
    if (pk_cyc - last_byte_cyc != 11) $display("FAIL flush_delay: got %0d want 11", pk_cyc - last_byte_cyc); else n_pass++;
    repeat (25) tick();
    n_checks++;
    if (pk_cnt - pk0 != 1) $display("FAIL flush_no_repeat: got %0d want 1", pk_cnt - pk0); else n_pass++;
  endtask
`endif

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_word();
    test_swap();
    test_streaming();
    test_backpressure();
    test_midword_stall();
    test_reset_midword();
    test_random();
`ifdef FX2_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
